// File: rtl/tinycpu_pkg.sv
// Shared tinycpu definitions: opcodes, decoded-word field positions and
// execute-stage FSM states.
package tinycpu_pkg;

  localparam logic [3:0] OP_NOP = 4'd0;
  localparam logic [3:0] OP_ADD = 4'd1;
  localparam logic [3:0] OP_SUB = 4'd2;
  localparam logic [3:0] OP_AND = 4'd3;
  localparam logic [3:0] OP_OR  = 4'd4;
  localparam logic [3:0] OP_XOR = 4'd5;
  localparam logic [3:0] OP_LI  = 4'd6;
  localparam logic [3:0] OP_LD  = 4'd7;
  localparam logic [3:0] OP_ST  = 4'd8;

  localparam int OP_MSB   = 31;
  localparam int OP_LSB   = 28;
  localparam int RD_MSB   = 26;
  localparam int RD_LSB   = 24;
  localparam int RS_MSB   = 22;
  localparam int RS_LSB   = 20;
  localparam int IMM_MSB  = 15;
  localparam int IMM_LSB  = 0;
  localparam int ADDR_LSB = 0;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_MEM  = 2'd2,
    S_OUT  = 2'd3
  } exec_state_e;

  function automatic logic is_mem_op(input logic [3:0] op);
    return (op == OP_LD) || (op == OP_ST);
  endfunction

endpackage

// File: rtl/regfile_8x32.sv
// Register file: two combinational read ports, one synchronous write port,
// synchronous clear on reset.
module regfile_8x32 #(
  parameter int DATA_W = 32,
  parameter int NREGS  = 8,
  parameter int AW     = $clog2(NREGS)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [AW-1:0]     i_ra,
  output logic [DATA_W-1:0] o_rdata_a,
  input  logic [AW-1:0]     i_rb,
  output logic [DATA_W-1:0] o_rdata_b,
  input  logic              i_we,
  input  logic [AW-1:0]     i_wa,
  input  logic [DATA_W-1:0] i_wdata
);

  logic [DATA_W-1:0] r_regs [NREGS];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < NREGS; i++) begin
        r_regs[i] <= '0;
      end
    end else if (i_we) begin
      r_regs[i_wa] <= i_wdata;
    end
  end

  assign o_rdata_a = r_regs[i_ra];
  assign o_rdata_b = r_regs[i_rb];

endmodule

// File: rtl/instruction_execute.sv
// tinycpu execute stage: accepts one decoded word, runs it against the
// register file or the shared memory port, and hands the result downstream.
module instruction_execute
  import tinycpu_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 10,
  parameter int NREGS  = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              DIR,
  output logic              ack_from,
  input  logic [DATA_W-1:0] data_in,
  output logic              DOR,
  input  logic              ack_to,
  output logic [DATA_W-1:0] data_out,
  output logic              illegal_op,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_di,
  input  logic [DATA_W-1:0] mem_do,
  input  logic              mem_do_ack
);

  localparam int AW = $clog2(NREGS);

  exec_state_e       r_state;
  logic [DATA_W-1:0] r_instr;

  logic [3:0]        w_op;
  logic [AW-1:0]     w_rd;
  logic [AW-1:0]     w_rs;
  logic [15:0]       w_imm;
  logic [ADDR_W-1:0] w_addr;
  logic [DATA_W-1:0] w_rd_val;
  logic [DATA_W-1:0] w_rs_val;
  logic [DATA_W-1:0] w_alu_result;
  logic              w_alu_wr;
  logic              w_illegal;
  logic              w_rf_we;
  logic [DATA_W-1:0] w_rf_wdata;
  logic              w_unused;

  assign w_op   = r_instr[OP_MSB:OP_LSB];
  assign w_rd   = r_instr[RD_MSB:RD_LSB];
  assign w_rs   = r_instr[RS_MSB:RS_LSB];
  assign w_imm  = r_instr[IMM_MSB:IMM_LSB];
  assign w_addr = r_instr[ADDR_LSB +: ADDR_W];
  assign w_unused = &{1'b0, r_instr[27], r_instr[23], r_instr[19:16]};

  regfile_8x32 #(
    .DATA_W(DATA_W),
    .NREGS (NREGS),
    .AW    (AW)
  ) u_regfile (
    .clk      (clk),
    .reset    (reset),
    .i_ra     (w_rd),
    .o_rdata_a(w_rd_val),
    .i_rb     (w_rs),
    .o_rdata_b(w_rs_val),
    .i_we     (w_rf_we),
    .i_wa     (w_rd),
    .i_wdata  (w_rf_wdata)
  );

  always_comb begin
    w_alu_result = '0;
    w_alu_wr     = 1'b0;
    w_illegal    = 1'b0;
    case (w_op)
      OP_NOP: ;
      OP_ADD: begin w_alu_result = w_rd_val + w_rs_val; w_alu_wr = 1'b1; end
      OP_SUB: begin w_alu_result = w_rd_val - w_rs_val; w_alu_wr = 1'b1; end
      OP_AND: begin w_alu_result = w_rd_val & w_rs_val; w_alu_wr = 1'b1; end
      OP_OR:  begin w_alu_result = w_rd_val | w_rs_val; w_alu_wr = 1'b1; end
      OP_XOR: begin w_alu_result = w_rd_val ^ w_rs_val; w_alu_wr = 1'b1; end
      OP_LI:  begin w_alu_result = {{(DATA_W-16){1'b0}}, w_imm}; w_alu_wr = 1'b1; end
      OP_LD, OP_ST: ;
      default: w_illegal = 1'b1;
    endcase
  end

  // Register writes happen either at the end of EXEC (ALU/LI) or on the
  // memory completion cycle (LD); reset priority in the regfile drops both.
  assign w_rf_we    = ((r_state == S_EXEC) && w_alu_wr) ||
                      ((r_state == S_MEM) && mem_do_ack && (w_op == OP_LD));
  assign w_rf_wdata = (r_state == S_MEM) ? mem_do : w_alu_result;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_instr    <= '0;
      ack_from   <= 1'b0;
      DOR        <= 1'b0;
      data_out   <= '0;
      illegal_op <= 1'b0;
      mem_en     <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_di     <= '0;
    end else begin
      ack_from <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (DIR) begin
            r_instr  <= data_in;
            ack_from <= 1'b1;
            r_state  <= S_EXEC;
          end
        end
        S_EXEC: begin
          if (is_mem_op(w_op)) begin
            mem_en   <= 1'b1;
            mem_we   <= (w_op == OP_ST);
            mem_addr <= w_addr;
            if (w_op == OP_ST) begin
              mem_di <= w_rd_val;
            end
            r_state  <= S_MEM;
          end else begin
            data_out   <= w_alu_result;
            illegal_op <= w_illegal;
            DOR        <= 1'b1;
            r_state    <= S_OUT;
          end
        end
        S_MEM: begin
          if (mem_do_ack) begin
            mem_en     <= 1'b0;
            mem_we     <= 1'b0;
            data_out   <= (w_op == OP_LD) ? mem_do : mem_di;
            illegal_op <= 1'b0;
            DOR        <= 1'b1;
            r_state    <= S_OUT;
          end
        end
        S_OUT: begin
          if (ack_to) begin
            DOR     <= 1'b0;
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_instruction_execute.sv
// Self-checking bench for instruction_execute: directed cases plus random
// instruction streams against an architectural register/memory model.
module tb_instruction_execute;

  logic        clk = 1'b0;
  logic        reset;
  logic        DIR;
  logic        ack_from;
  logic [31:0] data_in;
  logic        DOR;
  logic        ack_to;
  logic [31:0] data_out;
  logic        illegal_op;
  logic        mem_en;
  logic        mem_we;
  logic [9:0]  mem_addr;
  logic [31:0] mem_di;
  logic [31:0] mem_do;
  logic        mem_do_ack;

  always #5 clk = ~clk;

  instruction_execute #(
    .DATA_W(32),
    .ADDR_W(10),
    .NREGS (8)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .DIR       (DIR),
    .ack_from  (ack_from),
    .data_in   (data_in),
    .DOR       (DOR),
    .ack_to    (ack_to),
    .data_out  (data_out),
    .illegal_op(illegal_op),
    .mem_en    (mem_en),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_di    (mem_di),
    .mem_do    (mem_do),
    .mem_do_ack(mem_do_ack)
  );

  int checks = 0;
  int errors = 0;

  logic [31:0] m_regs [8];
  logic [31:0] m_mem  [1024];

  bit          exp_mem;
  logic        exp_we;
  logic [9:0]  exp_addr;
  logic [31:0] exp_di;
  logic [31:0] exp_data;
  logic        exp_ill;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
    end
  endtask

  function automatic logic [31:0] mk(input logic [3:0] op, input logic [2:0] rd,
                                     input logic [2:0] rs, input logic [15:0] imm);
    return {op, 1'b0, rd, 1'b0, rs, 4'b0, imm};
  endfunction

  // Every cycle: whatever the DUT presents must match the model's expectation.
  always @(negedge clk) begin
    if (!reset) begin
      if (DOR) begin
        chk("dor_data", data_out, exp_data);
        chk("dor_illegal", {31'b0, illegal_op}, {31'b0, exp_ill});
      end
      if (mem_en) begin
        chk("mem_en_legal", {31'b0, exp_mem}, 32'd1);
        if (exp_mem) begin
          chk("mem_we", {31'b0, mem_we}, {31'b0, exp_we});
          chk("mem_addr", {22'b0, mem_addr}, {22'b0, exp_addr});
          if (exp_we) chk("mem_di", mem_di, exp_di);
        end
      end
    end
  end

  // Sets the expectation for word w from the architectural model and
  // commits the model's register/memory side effects.
  task automatic model_step(input logic [31:0] w);
    logic [3:0]  op;
    logic [2:0]  rd, rs;
    logic [31:0] a, b, r;
    bit          wr;
    op = w[31:28]; rd = w[26:24]; rs = w[22:20];
    a = m_regs[rd]; b = m_regs[rs];
    r = 32'd0; wr = 1'b0;
    exp_mem = 1'b0; exp_we = 1'b0; exp_ill = 1'b0;
    exp_addr = w[9:0]; exp_di = a;
    case (op)
      4'd0: r = 32'd0;
      4'd1: begin r = a + b; wr = 1'b1; end
      4'd2: begin r = a - b; wr = 1'b1; end
      4'd3: begin r = a & b; wr = 1'b1; end
      4'd4: begin r = a | b; wr = 1'b1; end
      4'd5: begin r = a ^ b; wr = 1'b1; end
      4'd6: begin r = {16'h0, w[15:0]}; wr = 1'b1; end
      4'd7: begin exp_mem = 1'b1; r = m_mem[w[9:0]]; wr = 1'b1; end
      4'd8: begin exp_mem = 1'b1; exp_we = 1'b1; r = a; m_mem[w[9:0]] = a; end
      default: exp_ill = 1'b1;
    endcase
    if (wr) m_regs[rd] = r;
    exp_data = r;
  endtask

  task automatic do_instr(input logic [31:0] w, input int mem_dly, input int ack_dly,
                          output logic [31:0] res);
    model_step(w);
    res = exp_data;
    DIR = 1'b1; data_in = w;
    @(posedge clk); #1;
    chk("ack_from_c1", {31'b0, ack_from}, 32'd1);
    DIR = 1'b0; data_in = $urandom;
    @(posedge clk); #1;
    chk("ack_from_pulse", {31'b0, ack_from}, 32'd0);
    if (exp_mem) begin
      chk("mem_en_c2", {31'b0, mem_en}, 32'd1);
      chk("dor_low_c2", {31'b0, DOR}, 32'd0);
      for (int i = 0; i < mem_dly; i++) begin
        ack_to = 1'($urandom);
        DIR = 1'($urandom);
        @(posedge clk); #1;
        chk("mem_en_held", {31'b0, mem_en}, 32'd1);
        chk("dor_low_mem", {31'b0, DOR}, 32'd0);
      end
      ack_to = 1'b0; DIR = 1'b0;
      mem_do = exp_we ? $urandom : m_mem[mem_addr];
      mem_do_ack = 1'b1;
      @(posedge clk); #1;
      mem_do_ack = 1'b0; mem_do = $urandom;
      chk("mem_en_drop", {31'b0, mem_en}, 32'd0);
    end
    chk("dor_rise", {31'b0, DOR}, 32'd1);
    for (int i = 0; i < ack_dly; i++) begin
      mem_do_ack = 1'($urandom); mem_do = $urandom;
      @(posedge clk); #1;
      chk("dor_held", {31'b0, DOR}, 32'd1);
    end
    mem_do_ack = 1'b0;
    ack_to = 1'b1;
    @(posedge clk); #1;
    ack_to = 1'b0;
    chk("dor_drop", {31'b0, DOR}, 32'd0);
    exp_mem = 1'b0;
  endtask

  // LD r3 from 5, then reset either while waiting on memory or while in OUT.
  task automatic reset_mid(input bit in_out);
    logic [31:0] res;
    model_step(mk(4'd7, 3'd3, 3'd0, 16'h0005));
    DIR = 1'b1; data_in = mk(4'd7, 3'd3, 3'd0, 16'h0005);
    @(posedge clk); #1;
    DIR = 1'b0;
    @(posedge clk); #1;
    chk("rst_mem_en_before", {31'b0, mem_en}, 32'd1);
    if (in_out) begin
      mem_do = m_mem[mem_addr]; mem_do_ack = 1'b1;
      @(posedge clk); #1;
      mem_do_ack = 1'b0;
      chk("rst_dor_before", {31'b0, DOR}, 32'd1);
    end else begin
      repeat (2) @(posedge clk);
      #1;
    end
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    exp_mem = 1'b0;
    for (int i = 0; i < 8; i++) m_regs[i] = 32'd0;
    chk("rst_mem_en", {31'b0, mem_en}, 32'd0);
    chk("rst_dor", {31'b0, DOR}, 32'd0);
    chk("rst_data_out", data_out, 32'd0);
    chk("rst_mem_addr", {22'b0, mem_addr}, 32'd0);
    do_instr(mk(4'd4, 3'd3, 3'd3, 16'h0), 0, 0, res);
    chk("pin_r3_cleared", res, 32'd0);
    do_instr(mk(4'd6, 3'd2, 3'd0, 16'hA5A5), 0, 1, res);
    chk("pin_li_after_rst", res, 32'h0000A5A5);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog time limit reached");
    $fatal(1);
  end

  initial begin
    logic [31:0] res, w;
    logic [3:0]  op;
    reset = 1'b1; DIR = 1'b0; data_in = '0; ack_to = 1'b0;
    mem_do = '0; mem_do_ack = 1'b0;
    exp_mem = 1'b0; exp_we = 1'b0; exp_addr = '0; exp_di = '0;
    exp_data = '0; exp_ill = 1'b0;
    for (int i = 0; i < 8; i++) m_regs[i] = 32'd0;
    for (int i = 0; i < 1024; i++) m_mem[i] = $urandom;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    chk("reset_dor", {31'b0, DOR}, 32'd0);
    chk("reset_ack_from", {31'b0, ack_from}, 32'd0);
    chk("reset_illegal", {31'b0, illegal_op}, 32'd0);
    chk("reset_mem_en", {31'b0, mem_en}, 32'd0);
    chk("reset_mem_we", {31'b0, mem_we}, 32'd0);
    chk("reset_data_out", data_out, 32'd0);
    chk("reset_mem_addr", {22'b0, mem_addr}, 32'd0);
    chk("reset_mem_di", mem_di, 32'd0);

    do_instr(mk(4'd6, 3'd1, 3'd0, 16'h1234), 0, 3, res);
    chk("pin_li", res, 32'h00001234);
    do_instr(mk(4'd6, 3'd1, 3'd0, 16'hFFFF), 0, 0, res);
    chk("pin_li_ffff", res, 32'h0000FFFF);
    do_instr(mk(4'd6, 3'd2, 3'd0, 16'hFFFF), 0, 0, res);
    m_mem[10] = 32'hFFFFFFFF;
    do_instr(mk(4'd7, 3'd1, 3'd0, 16'd10), 1, 0, res);
    chk("pin_ld_ones", res, 32'hFFFFFFFF);
    do_instr(mk(4'd6, 3'd2, 3'd0, 16'h0001), 0, 0, res);
    do_instr(mk(4'd1, 3'd1, 3'd2, 16'h0), 0, 1, res);
    chk("pin_add_wrap", res, 32'h00000000);
    do_instr(mk(4'd7, 3'd1, 3'd0, 16'd10), 0, 0, res);
    do_instr(mk(4'd2, 3'd2, 3'd1, 16'h0), 0, 0, res);
    chk("pin_sub_wrap", res, 32'h00000002);
    m_mem[11] = 32'hDEADBEEF;
    do_instr(mk(4'd7, 3'd1, 3'd0, 16'd11), 0, 0, res);
    do_instr(mk(4'd8, 3'd1, 3'd0, 16'h03FF), 3, 2, res);
    chk("pin_st", res, 32'hDEADBEEF);
    m_mem[5] = 32'hCAFEF00D;
    do_instr(mk(4'd7, 3'd3, 3'd0, 16'h0005), 2, 0, res);
    chk("pin_ld", res, 32'hCAFEF00D);
    do_instr(mk(4'd6, 3'd4, 3'd0, 16'h0000), 0, 0, res);
    do_instr(mk(4'd4, 3'd4, 3'd3, 16'h0), 0, 0, res);
    chk("pin_or", res, 32'hCAFEF00D);
    do_instr(32'hF4300005, 0, 1, res);
    chk("pin_illegal", res, 32'd0);
    do_instr(mk(4'd4, 3'd4, 3'd4, 16'h0), 0, 0, res);
    chk("pin_illegal_no_write", res, 32'hCAFEF00D);
    do_instr(mk(4'd5, 3'd1, 3'd1, 16'h0), 0, 0, res);
    chk("pin_xor_self", res, 32'd0);

    reset_mid(1'b0);
    reset_mid(1'b1);

    for (int n = 0; n < 200; n++) begin
      if ($urandom_range(0, 4) == 0) op = 4'($urandom_range(9, 15));
      else                           op = 4'($urandom_range(0, 8));
      w = $urandom;
      w[31:28] = op;
      w[9:0] = ($urandom_range(0, 1) == 1) ? 10'($urandom_range(0, 7))
                                           : (10'h3F8 | 10'($urandom_range(0, 7)));
      do_instr(w, $urandom_range(0, 4), $urandom_range(0, 3), res);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
